// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared word width, opcode encodings and sequencer state set.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD = 16;

    // Opcode field position inside an instruction word (IR[8:6]).
    localparam int c_op_lsb = 6;

    localparam logic [2:0] c_op_mv   = 3'b000;
    localparam logic [2:0] c_op_mvi  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b011;
    localparam logic [2:0] c_op_halt = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_FETCH_IMM = 3'd3,
        ST_LATCH_IMM = 3'd4,
        ST_ISSUE     = 3'd5,
        ST_WAIT      = 3'd6,
        ST_HALT      = 3'd7
    } seq_state_t;

    // Program words consumed by an instruction: mvi carries an immediate.
    function automatic logic [1:0] instr_len(input logic [2:0] op);
        return (op == c_op_mvi) ? 2'd2 : 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : prog_sequencer_if
// Brief  : Control, program-memory and CPU handshake bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface prog_sequencer_if #(
    parameter int WORD   = cpu_pkg::WORD,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD-1:0]   mem_rdata;
    logic [WORD-1:0]   cpu_din;
    logic              cpu_run;
    logic              cpu_done;
    logic              busy;
    logic              halted;
    logic              timeout;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_count;

    modport master (
        input  start, mem_rdata, cpu_done,
        output mem_addr, cpu_din, cpu_run, busy, halted, timeout, pc, instr_count
    );

    modport slave (
        output start, mem_rdata, cpu_done,
        input  mem_addr, cpu_din, cpu_run, busy, halted, timeout, pc, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module : seq_watchdog
// Brief  : Reloadable down-counter; flags expiry when it has counted out.
// Rev    : 1.0  initial release
// ============================================================================
module seq_watchdog #(
    parameter int WD_MAX = 8
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic i_clr,
    input  wire logic i_en,
    output wire logic o_expire
);
    localparam int c_cnt_w = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;

    logic [c_cnt_w-1:0] r_count;

    // Reload with WD_MAX-1 so that the WD_MAX-th enabled cycle sees zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= c_cnt_w'(WD_MAX - 1);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign o_expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module : prog_sequencer
// Brief  : Fetches instructions from program memory and issues them to a CPU.
// Rev    : 1.0  initial release
// ============================================================================
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int WORD   = cpu_pkg::WORD,
    parameter int ADDR_W = 5,
    parameter int WD_MAX = 8
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    prog_sequencer_if.master bus
);
    seq_state_t        r_state;
    seq_state_t        w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_instr_count;
    logic              r_timeout;
    logic [WORD-1:0]   r_ir;
    logic [WORD-1:0]   r_imm;

    logic [2:0]        w_ir_op;
    logic [2:0]        w_rd_op;
    logic              w_ir_is_mvi;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_start_ok;
    logic              w_retire;
    logic              w_expire_hit;
    logic              w_wd_clr;
    logic              w_wd_en;
    logic              w_wd_expire;

    assign w_ir_op     = r_ir[c_op_lsb +: 3];
    assign w_rd_op     = bus.mem_rdata[c_op_lsb +: 3];
    assign w_ir_is_mvi = (w_ir_op == c_op_mvi);
    assign w_pc_plus1  = r_pc + ADDR_W'(1);
    assign w_pc_inc    = r_pc + ADDR_W'(instr_len(w_ir_op));

    assign w_start_ok   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_retire     = (r_state == ST_WAIT) && bus.cpu_done;
    assign w_expire_hit = (r_state == ST_WAIT) && !bus.cpu_done && w_wd_expire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wd_clr    = 1'b0;
        w_wd_en     = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_rd_op == c_op_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (w_rd_op == c_op_mvi) begin
                    w_state_nxt = ST_FETCH_IMM;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_FETCH_IMM: begin
                w_state_nxt = ST_LATCH_IMM;
            end
            ST_LATCH_IMM: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_wd_clr    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                // A done arriving on the last watchdog cycle still retires.
                if (bus.cpu_done) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc          <= '0;
            r_instr_count <= '0;
            r_timeout     <= 1'b0;
            r_ir          <= '0;
            r_imm         <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc          <= '0;
                r_instr_count <= '0;
                r_timeout     <= 1'b0;
            end
            if (r_state == ST_LATCH) begin
                r_ir <= bus.mem_rdata;
            end
            if (r_state == ST_LATCH_IMM) begin
                r_imm <= bus.mem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_pc_inc;
                if (r_instr_count != 16'hFFFF) begin
                    r_instr_count <= r_instr_count + 16'd1;
                end
            end
            if (w_expire_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    seq_watchdog #(
        .WD_MAX (WD_MAX)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    // The immediate is addressed for both of its fetch cycles.
    assign bus.mem_addr    = ((r_state == ST_FETCH_IMM) || (r_state == ST_LATCH_IMM))
                             ? w_pc_plus1 : r_pc;
    assign bus.cpu_din     = ((r_state == ST_WAIT) && w_ir_is_mvi) ? r_imm : r_ir;
    assign bus.cpu_run     = (r_state == ST_ISSUE);
    assign bus.busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.timeout     = r_timeout;
    assign bus.pc          = r_pc;
    assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter WORD, default 16: data width of cpu_din and mem_rdata.
REQ-002 SHALL have parameter ADDR_W, default 5: program address width, 32 words.
REQ-003 SHALL have parameter WD_MAX, default 8: maximum WAIT cycles before timeout.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins execution at address 0.
REQ-007 mem_addr  output  ADDR_W  program memory read address.
REQ-008 mem_rdata  input  WORD  program memory read data, valid one cycle after mem_addr.
REQ-009 cpu_din  output  WORD  drives CPU Din.
REQ-010 cpu_run  output  1  drives CPU run.
REQ-011 cpu_done  input  1  CPU done.
REQ-012 busy  output  1  high in any state except IDLE and HALT.
REQ-013 halted  output  1  high in HALT.
REQ-014 timeout  output  1  sticky; set on watchdog expiry.
REQ-015 pc  output  ADDR_W  current instruction address.
REQ-016 instr_count  output  16  instructions retired since start.

Function
REQ-017 SHALL implement states IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, WAIT, HALT.
REQ-018 IDLE/HALT: start=1 -> clear pc, instr_count and timeout, go FETCH. Start is ignored in all other states.
REQ-019 FETCH: mem_addr=pc; next state LATCH.
REQ-020 LATCH: capture mem_rdata into the instruction register. If IR[8:6]=111 (halt), go HALT. If IR[8:6]=001 (mvi), go FETCH_IMM. Otherwise go ISSUE.
REQ-021 FETCH_IMM: mem_addr=pc+1 mod 2^ADDR_W; LATCH_IMM captures the immediate; next state ISSUE.
REQ-022 ISSUE: cpu_din=instruction and cpu_run=1 for exactly one cycle; next state WAIT.
REQ-023 WAIT: cpu_run=0; cpu_din=immediate for mvi, else held at the instruction word.
REQ-024 WAIT, cpu_done=1: increment pc by 2 (mvi) or 1 (other), mod 2^ADDR_W; instr_count+1 saturating at 0xFFFF; next state FETCH.
REQ-025 cpu_done SHALL be sampled only in WAIT and ignored in all other states.
REQ-026 Watchdog: counts cycles in WAIT. If cpu_done is still 0 on the WD_MAX-th WAIT cycle: set timeout, go HALT, pc unchanged, instr_count not incremented.
REQ-027 Issue latency from FETCH entry: 2 cycles for non-mvi, 4 cycles for mvi. Instruction-to-instruction time = latency + 1 + WAIT cycles.
REQ-028 Address wrap: pc and pc+1 wrap modulo 2^ADDR_W. An mvi at address 31 reads its immediate from address 0, and pc becomes 1 after retirement.
REQ-029 mem_addr SHALL equal pc in every state other than FETCH_IMM and LATCH_IMM.
REQ-030 Exactly one cpu_run pulse per issued instruction; no new issue before cpu_done is seen.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE and clear pc, mem_addr, cpu_din, cpu_run, busy, halted, timeout, instr_count and the watchdog to 0.
REQ-032 Reset asserted in any state, including WAIT mid-instruction, SHALL abort the instruction with no pc or instr_count update.
REQ-033 After reset release, outputs SHALL hold their reset values until the first start pulse.

Structure
REQ-034 The shared package cpu_pkg SHALL hold WORD, the opcode constants (mv=000, mvi=001, add=010, sub=011, halt=111) and the state enumeration.
REQ-035 The watchdog SHALL be one sub-module, seq_watchdog, a clear/enable down-counter with an expire flag.

Verification
REQ-036 Program memory [0x0040, 0x0005, 0x0008, 0x0081, 0x01C0], CPU model with done on T1/T3: start -> one run pulse at each of pc 0, 2, 3; cpu_din=0x0005 during the first WAIT; HALT with pc=4, instr_count=3, halted=1.
REQ-037 cpu_done held 0 after an issue: timeout=1 and HALT on the 8th WAIT cycle; pc unchanged; a following start clears timeout and re-runs from 0.
REQ-038 Program memory[31]=0x0040, [0]=0x1234, pc forced to 31 via a prior program: mem_addr=0 in FETCH_IMM; cpu_din=0x1234 in WAIT; pc=1 after done.
REQ-039 resetn pulsed low during WAIT: cpu_run=0, busy=0, pc=0, instr_count=0 before the next clock edge; no spurious run pulse after release.
REQ-040 start pulsed while busy, and cpu_done pulsed during FETCH: no state change, no pc change, no extra run pulse.
